cpu_run_ctrl: RTL
=================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 2: number of cycles the core reset is held asserted.
REQ-002 Parameter MAX_CYCLES, default 20: maximum RUN cycles before timeout.
REQ-003 Parameter STALL_LIMIT, default 4: count of consecutive unchanged-PC cycles that declares a stall.
REQ-004 Parameter TRACE_DEPTH, default 8, power of two >= 2: PC trace buffer entries.
REQ-005 Parameter HALT_INST, default 32'h0000006F: instruction encoding that signals halt.
REQ-006 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-007 Port rst_n, input, 1: synchronous, active-low reset.
REQ-008 Port start, input, 1: begins a run from IDLE or DONE.
REQ-009 Port pc, input, `ADDR_LEN: current core PC.
REQ-010 Port inst, input, `INSTR_LEN: current core instruction.
REQ-011 Port core_rst, output, 1: active-high reset driven to the CPU core.
REQ-012 Port running, output, 1: high while in RUN.
REQ-013 Port done, output, 1: high while in DONE.
REQ-014 Port stop_cause, output, 2: 0 none, 1 HALT, 2 TIMEOUT, 3 STALL.
REQ-015 Port cycle_cnt, output, $clog2(MAX_CYCLES+1): number of RUN cycles elapsed.
REQ-016 Port trace_idx, input, $clog2(TRACE_DEPTH): trace read index; 0 selects the newest entry.
REQ-017 Port trace_pc, output, `ADDR_LEN: PC stored at trace_idx; combinational read.
REQ-018 Port trace_count, output, $clog2(TRACE_DEPTH)+1: number of valid trace entries, saturating at TRACE_DEPTH.

Function
REQ-019 FSM states are IDLE, RESET, RUN and DONE, registered and one state per cycle.
REQ-020 In IDLE, start=1 causes a transition to RESET on the next cycle; otherwise the FSM stays in IDLE.
REQ-021 RESET drives core_rst=1 for exactly RST_CYCLES cycles, then transitions to RUN; start is ignored while in RESET.
REQ-022 Entering RESET clears cycle_cnt, stop_cause, the stall counter and trace_count.
REQ-023 Each RUN cycle increments cycle_cnt, writes pc into the trace buffer and increments trace_count (saturating).
REQ-024 The trace buffer is circular: write pointer wraps modulo TRACE_DEPTH, and once full the oldest entry is overwritten.
REQ-025 trace_idx >= trace_count drives trace_pc to 0.
REQ-026 The stall counter increments while pc equals the previous cycle's pc, and resets to 0 when pc changes; the first RUN cycle never counts as a stall.
REQ-027 In RUN, the following stop conditions are evaluated every cycle:
- inst == HALT_INST -> HALT
- stall counter reaching STALL_LIMIT-1 with pc still unchanged -> STALL
- cycle_cnt == MAX_CYCLES-1 -> TIMEOUT
REQ-028 When stop conditions coincide, the priority is HALT, then STALL, then TIMEOUT.
REQ-029 On a stop, the stopping cycle is counted and traced, the FSM moves to DONE next cycle, and stop_cause is latched.
REQ-030 DONE holds cycle_cnt, stop_cause and the trace contents; the trace stays readable.
REQ-031 start=1 in DONE transitions to RESET, beginning a fresh run.
REQ-032 core_rst=0 in RUN and DONE; core_rst=1 in IDLE, keeping the core quiescent.

Reset
REQ-033 rst_n=0 at a rising edge forces IDLE from any state, including mid-RESET and mid-RUN.
REQ-034 Under reset: core_rst=1, running=0, done=0, stop_cause=0, cycle_cnt=0, trace_count=0 and the write pointer is 0; trace RAM contents are don't-care.

Structure
REQ-035 State encodings and stop_cause codes live in a shared package/defines file alongside `ADDR_LEN and `INSTR_LEN.
REQ-036 The trace buffer is a sub-module pc_trace_buf, parametrised by width and depth, with write-enable, clear and a newest-relative read index.

Verification
REQ-037 Reset sequence: rst_n low for 2 cycles, then start pulse -> core_rst high exactly 2 cycles, then running=1 and cycle_cnt counting 1, 2, 3, ...
REQ-038 Halt: inst=32'h0000006F on RUN cycle 5 -> done=1 next cycle, stop_cause=1, cycle_cnt=5.
REQ-039 Timeout: PC incrementing by 4 each cycle with no halt -> stop_cause=2, cycle_cnt=20 in DONE.
REQ-040 Stall versus timeout: PC frozen at 0x10 from cycle 17 -> stop_cause=3 at cycle 20, winning over TIMEOUT.
REQ-041 Trace wrap: 12 cycles with PCs 0x00, 0x04, ... 0x2C -> trace_count=8; idx0=0x2C, idx7=0x10.
REQ-042 Mid-run reset: rst_n low during RUN cycle 3 -> IDLE, core_rst=1, trace_count=0; a subsequent start reruns cleanly.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared widths, FSM state encoding and stop-cause codes for the run controller.
`ifndef CPU_RUN_CTRL_DEFS
`define CPU_RUN_CTRL_DEFS
`define ADDR_LEN 32
`define INSTR_LEN 32
`endif

package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STOP_NONE    = 2'd0,
    STOP_HALT    = 2'd1,
    STOP_TIMEOUT = 2'd2,
    STOP_STALL   = 2'd3
  } stop_t;

  // Coinciding stop conditions resolve HALT first, then STALL, then TIMEOUT.
  function automatic stop_t pick_stop(input logic halt, input logic stall);
    return halt ? STOP_HALT : (stall ? STOP_STALL : STOP_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/observation bundle between a test harness (master) and the run controller (slave).
interface cpu_run_ctrl_if #(
  parameter int MAX_CYCLES  = 20,
  parameter int TRACE_DEPTH = 8
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int IW = $clog2(TRACE_DEPTH);

  // No valid/ready pairs here: start is a level sampled on each rising edge and
  // only acted on in IDLE or DONE; every other signal is a plain per-cycle value.
  logic                   start;
  logic [`ADDR_LEN-1:0]   pc;
  logic [`INSTR_LEN-1:0]  inst;
  logic                   core_rst;
  logic                   running;
  logic                   done;
  logic [1:0]             stop_cause;
  logic [CW-1:0]          cycle_cnt;
  logic [IW-1:0]          trace_idx;
  logic [`ADDR_LEN-1:0]   trace_pc;
  logic [IW:0]            trace_count;

  modport master (
    output start, pc, inst, trace_idx,
    input  core_rst, running, done, stop_cause, cycle_cnt, trace_pc, trace_count
  );

  modport slave (
    input  start, pc, inst, trace_idx,
    output core_rst, running, done, stop_cause, cycle_cnt, trace_pc, trace_count
  );
endinterface

// File: rtl/cpu_run_ctrl_trace.sv
// Circular PC trace buffer; read index is relative to the newest entry.
module pc_trace_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IW-1:0]    i_ridx,
  output logic [WIDTH-1:0] o_rdata,
  output logic [IW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IW-1:0]    r_wptr;
  logic [IW:0]      r_count;
  logic [IW-1:0]    w_raddr;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_we) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_count != (IW+1)'(DEPTH)) r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the subtraction wraps onto the ring.
  assign w_raddr = r_wptr - i_ridx - 1'b1;
  assign o_rdata = ({1'b0, i_ridx} < r_count) ? r_mem[w_raddr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Drives a CPU core through reset and a bounded run, stopping on halt, stall or timeout.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          RST_CYCLES  = 2,
  parameter int          MAX_CYCLES  = 20,
  parameter int          STALL_LIMIT = 4,
  parameter int          TRACE_DEPTH = 8,
  parameter logic [31:0] HALT_INST   = 32'h0000006F
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_run_ctrl_if.slave  bus,
  output state_t         o_dbg_state
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_t               r_state;
  stop_t                r_stop_cause;
  logic                 r_core_rst;
  logic                 r_running;
  logic                 r_done;
  logic [CW-1:0]        r_cycle_cnt;
  logic [SW-1:0]        r_stall_cnt;
  logic [RW-1:0]        r_rst_cnt;
  logic [`ADDR_LEN-1:0] r_prev_pc;
  logic                 r_prev_valid;

  logic w_clr, w_run, w_same, w_halt, w_stall, w_timeout;

  assign w_clr     = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_run     = (r_state == ST_RUN);
  assign w_same    = r_prev_valid && (bus.pc == r_prev_pc);
  assign w_halt    = (bus.inst == HALT_INST);
  // Stall fires on the STALL_LIMIT-th consecutive cycle at one PC, i.e. when
  // this repeat takes the counter to STALL_LIMIT-1.
  assign w_stall   = w_same && (r_stall_cnt == SW'(STALL_LIMIT - 2));
  assign w_timeout = (r_cycle_cnt == CW'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_stop_cause <= STOP_NONE;
      r_core_rst   <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_rst_cnt    <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_clr) begin
      r_state      <= ST_RESET;
      r_stop_cause <= STOP_NONE;
      r_core_rst   <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_rst_cnt    <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
            r_state    <= ST_RUN;
            r_core_rst <= 1'b0;
            r_running  <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_cycle_cnt  <= r_cycle_cnt + 1'b1;
          r_prev_pc    <= bus.pc;
          r_prev_valid <= 1'b1;
          r_stall_cnt  <= w_same ? r_stall_cnt + 1'b1 : '0;
          if (w_halt || w_stall || w_timeout) begin
            r_state      <= ST_DONE;
            r_running    <= 1'b0;
            r_done       <= 1'b1;
            r_stop_cause <= pick_stop(w_halt, w_stall);
          end
        end
        default: ;
      endcase
    end
  end

  pc_trace_buf #(
    .WIDTH (`ADDR_LEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_run),
    .i_clr   (w_clr),
    .i_wdata (bus.pc),
    .i_ridx  (bus.trace_idx),
    .o_rdata (bus.trace_pc),
    .o_count (bus.trace_count)
  );

  assign bus.core_rst   = r_core_rst;
  assign bus.running    = r_running;
  assign bus.done       = r_done;
  assign bus.stop_cause = r_stop_cause;
  assign bus.cycle_cnt  = r_cycle_cnt;
  assign o_dbg_state    = r_state;
endmodule
